// File: rtl/reg_req_master.sv
// Command-to-register-bus request master: latches a host command, holds a level request until ack or timeout, then presents a response.
// Optional timed-out request counter enabled by defining REG_REQ_MASTER_TIMEOUT_CNT_EN.
module reg_req_master #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_timeout,
  output logic                  reg_req,
  output logic                  reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_ack,
  output logic [31:0]           timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(32'hdead_beef);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  rd_wr_q, rd_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  to_q, to_d;
  logic                  cmd_ready_q, reg_req_q, resp_valid_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rd_wr_d = rd_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_wr_d = cmd_rd_wr_L;
          addr_d  = cmd_addr;
          wdata_d = cmd_wr_data;
          timer_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack arriving on the expiry cycle still counts as a normal completion.
        if (reg_ack) begin
          rdata_d = reg_rd_data;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (timer_q == TLAST) begin
          rdata_d = DEAD;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      rd_wr_q      <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      to_q         <= 1'b0;
      cmd_ready_q  <= 1'b1;
      reg_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rd_wr_q      <= rd_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      to_q         <= to_d;
      cmd_ready_q  <= (state_d == IDLE);
      reg_req_q    <= (state_d == REQ);
      resp_valid_q <= (state_d == RESP);
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign reg_req      = reg_req_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = rdata_q;
  assign resp_timeout = to_q;
  assign reg_rd_wr_L  = rd_wr_q;
  assign reg_addr     = addr_q;
  assign reg_wr_data  = wdata_q;

`ifdef REG_REQ_MASTER_TIMEOUT_CNT_EN
  logic        to_inc;
  logic [31:0] to_cnt_q;

  assign to_inc = (state_q == REQ) && !reg_ack && (timer_q == TLAST);

  always_ff @(posedge clk) begin
    if (reset)       to_cnt_q <= '0;
    else if (to_inc) to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign timeout_cnt = to_cnt_q;
`else
  assign timeout_cnt = '0;
`endif

endmodule
